fft_bitrev_power: RTL and testbench

- Sits directly downstream of the 256-point FFT and consumes its complex output stream, which arrives scaled in bit-reversed order.
- Reorders the first N/2 bins (0..N/2-1) into natural order through a ping-pong buffer.
- Outputs the unsigned power re²+im² of each bin as a burst for the mel/feature stage.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_pp_ram.sv | 30 +++
 rtl/fft_bitrev_power.sv | 151 +++++++++++++++
 tb/tb_fft_bitrev_power.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and helpers, reused by the FFT top and the feature stages.
//   FftN, FftLog2N, FftWidth : default transform length, its log2, and sample width.
//   bitrev()                 : reverses the bit order of a FftLog2N-bit index.
package fft_pkg;

  localparam int unsigned FftN     = 256;
  localparam int unsigned FftLog2N = 8;
  localparam int unsigned FftWidth = 16;

  function automatic logic [FftLog2N-1:0] bitrev(input logic [FftLog2N-1:0] v);
    logic [FftLog2N-1:0] r;
    for (int i = 0; i < int'(FftLog2N); i++) begin
      r[i] = v[FftLog2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_ram.sv
// Dual-bank simple dual-port RAM for the bit-reversal ping-pong buffer.
// The address MSB selects the bank; contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address {bank, word}
//   wdata_i : write data
//   raddr_i : read address {bank, word}
//   rdata_o : registered read data, valid one cycle after raddr_i
module fft_pp_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [0:(1 << AddrWidth)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_bitrev_power.sv
// Reorders the first N/2 bins of a bit-reversed FFT output stream into natural
// order via a ping-pong buffer and emits re^2+im^2 per bin as a burst.
//   clock   : master clock
//   reset   : synchronous active-low reset
//   di_en   : input sample valid
//   di_re   : FFT real part (bit-reversed order, two's complement)
//   di_im   : FFT imag part (bit-reversed order, two's complement)
//   do_en   : output bin valid
//   do_idx  : natural-order bin index 0..N/2-1
//   do_pow  : unsigned re^2+im^2
//   do_last : high with do_en on bin N/2-1
//   busy    : read burst in progress
module fft_bitrev_power
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = FftWidth,
  parameter int unsigned N      = FftN,
  parameter int unsigned LOG2N  = FftLog2N,
  parameter int unsigned PWIDTH = 2 * WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              di_en,
  input  logic [WIDTH-1:0]  di_re,
  input  logic [WIDTH-1:0]  di_im,
  output logic              do_en,
  output logic [LOG2N-2:0]  do_idx,
  output logic [PWIDTH-1:0] do_pow,
  output logic              do_last,
  output logic              busy
);

  localparam logic [LOG2N-2:0] RdMax = {(LOG2N-1){1'b1}};

  // Write side
  logic [LOG2N-1:0] wr_cnt_q;
  logic             wr_bank_q;
  logic [LOG2N-1:0] wr_rev;
  logic             wr_we;
  logic             frame_end;

  assign wr_rev    = bitrev(wr_cnt_q);
  // Bin bitrev(k) is in the lower half exactly when its MSB (k[0]) is zero.
  assign wr_we     = di_en & ~wr_rev[LOG2N-1];
  assign frame_end = di_en && (wr_cnt_q == LOG2N'(N - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (di_en) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (frame_end) begin
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  // Read address generator
  logic             rd_active_q;
  logic [LOG2N-2:0] rd_cnt_q;
  logic             rd_bank_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_active_q <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
    end else if (frame_end) begin
      rd_active_q <= 1'b1;
      rd_cnt_q    <= '0;
      rd_bank_q   <= wr_bank_q;
    end else if (rd_active_q) begin
      rd_cnt_q <= rd_cnt_q + 1'b1;
      if (rd_cnt_q == RdMax) begin
        rd_active_q <= 1'b0;
      end
    end
  end

  logic [2*WIDTH-1:0] rd_data;

  fft_pp_ram #(
    .DataWidth(2 * WIDTH),
    .AddrWidth(LOG2N)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (wr_we),
    .waddr_i({wr_bank_q, wr_rev[LOG2N-2:0]}),
    .wdata_i({di_re, di_im}),
    .raddr_i({rd_bank_q, rd_cnt_q}),
    .rdata_o(rd_data)
  );

  // Stage 1: tags aligned with the RAM read latency
  logic             v1_q, last1_q;
  logic [LOG2N-2:0] idx1_q;

  // Stage 2: registered signed squares
  logic                     v2_q, last2_q;
  logic [LOG2N-2:0]         idx2_q;
  logic [PWIDTH-1:0]        re_sq_q, im_sq_q;
  logic signed [WIDTH-1:0]  rd_re, rd_im;
  logic signed [PWIDTH-1:0] re_ext, im_ext;

  assign rd_re  = rd_data[2*WIDTH-1:WIDTH];
  assign rd_im  = rd_data[WIDTH-1:0];
  assign re_ext = PWIDTH'(rd_re);
  assign im_ext = PWIDTH'(rd_im);

  always_ff @(posedge clock) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      idx1_q  <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      idx2_q  <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      do_en   <= 1'b0;
      do_last <= 1'b0;
      do_idx  <= '0;
      do_pow  <= '0;
      busy    <= 1'b0;
    end else begin
      v1_q    <= rd_active_q;
      last1_q <= rd_active_q && (rd_cnt_q == RdMax);
      idx1_q  <= rd_cnt_q;

      v2_q    <= v1_q;
      last2_q <= last1_q;
      idx2_q  <= idx1_q;
      // Squares are non-negative and at most 2^(2*WIDTH-2), so the unsigned sum cannot wrap.
      re_sq_q <= re_ext * re_ext;
      im_sq_q <= im_ext * im_ext;

      do_en   <= v2_q;
      do_last <= last2_q;
      do_idx  <= idx2_q;
      do_pow  <= re_sq_q + im_sq_q;

      if (frame_end) begin
        busy <= 1'b1;
      end else if (do_last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_power.sv
module tb_fft_bitrev_power;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        di_en = 1'b0;
  logic [15:0] di_re = '0;
  logic [15:0] di_im = '0;
  logic        do_en;
  logic [6:0]  do_idx;
  logic [31:0] do_pow;
  logic        do_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cap = 0;
  int busy_rises = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;

  logic [6:0]  q_idx[$];
  logic [31:0] q_pow[$];
  logic        q_last[$];
  int          q_first[$];

  fft_bitrev_power dut (
    .clock  (clock),
    .reset  (reset),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_idx (do_idx),
    .do_pow (do_pow),
    .do_last(do_last),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (do_en === 1'b1) begin
      q_idx.push_back(do_idx);
      q_pow.push_back(do_pow);
      q_last.push_back(do_last);
      if (prev_en !== 1'b1) q_first.push_back(cyc);
    end
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
    prev_en = do_en;
    prev_busy = busy;
  end

  function automatic int rev8(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
    return r;
  endfunction

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    @(negedge clock);
    di_en = 1'b1;
    di_re = re;
    di_im = im;
    last_cap = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      di_en = 1'b0;
    end
  endtask

  // mode 0: constant (cr, ci); mode 1: ramp re=k, im=0
  task automatic drive_frame(input int mode, input logic [15:0] cr, input logic [15:0] ci,
                             input bit gapped);
    for (int k = 0; k < 256; k++) begin
      if (mode == 1) send(16'(k), 16'h0000);
      else send(cr, ci);
      if (gapped) idle(2);
    end
  endtask

  task automatic wait_outputs(input int target, input int budget, input string name);
    int n = 0;
    while (q_pow.size() < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (q_pow.size() < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d outputs, required %0d", name, q_pow.size(), target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    di_en = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({do_en, do_last, busy, do_idx, do_pow} !== 42'd0) begin
      errors++;
      $display("FAIL reset_values: en=%b last=%b busy=%b idx=%0d pow=%0d required all 0",
               do_en, do_last, busy, do_idx, do_pow);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_constant();
    int base = q_pow.size();
    int fb = q_first.size();
    drive_frame(0, 16'd100, 16'd0, 1'b0);
    idle(1);
    wait_outputs(base + 128, 400, "constant");
    idle(10);
    checks++;
    if (q_pow.size() - base != 128) begin
      errors++;
      $display("FAIL constant_count: got %0d required 128", q_pow.size() - base);
    end
    for (int i = 0; i < 128 && base + i < q_pow.size(); i++) begin
      checks++;
      if (q_idx[base+i] !== 7'(i) || q_pow[base+i] !== 32'd10000 ||
          q_last[base+i] !== (i == 127)) begin
        errors++;
        $display("FAIL constant_bin%0d: idx=%0d pow=%0d last=%b required idx=%0d pow=10000 last=%b",
                 i, q_idx[base+i], q_pow[base+i], q_last[base+i], i, (i == 127));
      end
    end
    checks++;
    if (q_first.size() <= fb || q_first[fb] != last_cap + 3) begin
      errors++;
      $display("FAIL constant_latency: first do_en at cycle %0d required %0d",
               (q_first.size() > fb) ? q_first[fb] : -1, last_cap + 3);
    end
  endtask

  task automatic test_ramp(input bit gapped, input string name);
    int base = q_pow.size();
    int fb = q_first.size();
    drive_frame(1, 16'd0, 16'd0, gapped);
    idle(1);
    wait_outputs(base + 128, 400, name);
    idle(10);
    checks++;
    if (q_pow.size() - base != 128) begin
      errors++;
      $display("FAIL %s_count: got %0d required 128", name, q_pow.size() - base);
    end
    for (int i = 0; i < 128 && base + i < q_pow.size(); i++) begin
      int r = rev8(i);
      logic [31:0] exp_pow = 32'(r * r);
      checks++;
      if (q_idx[base+i] !== 7'(i) || q_pow[base+i] !== exp_pow ||
          q_last[base+i] !== (i == 127)) begin
        errors++;
        $display("FAIL %s_bin%0d: idx=%0d pow=%0d last=%b required idx=%0d pow=%0d last=%b",
                 name, i, q_idx[base+i], q_pow[base+i], q_last[base+i], i, exp_pow, (i == 127));
      end
    end
    checks++;
    if (q_first.size() <= fb || q_first[fb] != last_cap + 3) begin
      errors++;
      $display("FAIL %s_latency: first do_en at cycle %0d required %0d", name,
               (q_first.size() > fb) ? q_first[fb] : -1, last_cap + 3);
    end
  endtask

  task automatic test_extremes();
    int base = q_pow.size();
    drive_frame(0, 16'h8000, 16'h8000, 1'b0);
    idle(1);
    wait_outputs(base + 128, 400, "extremes");
    idle(10);
    for (int i = 0; i < 128 && base + i < q_pow.size(); i++) begin
      checks++;
      if (q_pow[base+i] !== 32'h8000_0000 || q_idx[base+i] !== 7'(i)) begin
        errors++;
        $display("FAIL extremes_bin%0d: idx=%0d pow=%h required idx=%0d pow=80000000",
                 i, q_idx[base+i], q_pow[base+i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base = q_pow.size();
    int fb = q_first.size();
    int rises0 = busy_rises;
    for (int f = 0; f < 3; f++) drive_frame(0, 16'(f + 1), 16'(f + 2), 1'b0);
    idle(1);
    wait_outputs(base + 384, 800, "back_to_back");
    idle(10);
    checks++;
    if (q_pow.size() - base != 384) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 384", q_pow.size() - base);
    end
    for (int i = 0; i < 384 && base + i < q_pow.size(); i++) begin
      int f = i / 128;
      int b = i % 128;
      logic [31:0] exp_pow = 32'((f + 1) * (f + 1) + (f + 2) * (f + 2));
      checks++;
      if (q_idx[base+i] !== 7'(b) || q_pow[base+i] !== exp_pow ||
          q_last[base+i] !== (b == 127)) begin
        errors++;
        $display("FAIL b2b_f%0d_bin%0d: idx=%0d pow=%0d last=%b required idx=%0d pow=%0d last=%b",
                 f, b, q_idx[base+i], q_pow[base+i], q_last[base+i], b, exp_pow, (b == 127));
      end
    end
    checks++;
    if (q_first.size() - fb != 3) begin
      errors++;
      $display("FAIL b2b_bursts: got %0d bursts required 3", q_first.size() - fb);
    end else begin
      checks++;
      if (q_first[fb+1] - q_first[fb] != 256 || q_first[fb+2] - q_first[fb+1] != 256) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d required 256,256",
                 q_first[fb+1] - q_first[fb], q_first[fb+2] - q_first[fb+1]);
      end
    end
    checks++;
    if (busy_rises - rises0 != 3) begin
      errors++;
      $display("FAIL b2b_busy_rises: got %0d required 3", busy_rises - rises0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int fb;
    for (int k = 0; k < 100; k++) send(16'd3, 16'd4);
    @(negedge clock);
    di_en = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    base = q_pow.size();
    fb = q_first.size();
    drive_frame(0, 16'd3, 16'd4, 1'b0);
    idle(1);
    wait_outputs(base + 128, 400, "reset_mid_frame");
    idle(10);
    checks++;
    if (q_pow.size() - base != 128) begin
      errors++;
      $display("FAIL rmf_count: got %0d required 128", q_pow.size() - base);
    end
    for (int i = 0; i < 128 && base + i < q_pow.size(); i++) begin
      checks++;
      if (q_idx[base+i] !== 7'(i) || q_pow[base+i] !== 32'd25) begin
        errors++;
        $display("FAIL rmf_bin%0d: idx=%0d pow=%0d required idx=%0d pow=25",
                 i, q_idx[base+i], q_pow[base+i], i);
      end
    end
    checks++;
    if (q_first.size() <= fb || q_first[fb] != last_cap + 3) begin
      errors++;
      $display("FAIL rmf_latency: first do_en at cycle %0d required %0d",
               (q_first.size() > fb) ? q_first[fb] : -1, last_cap + 3);
    end
  endtask

  task automatic test_reset_mid_burst();
    int base = q_pow.size();
    int cnt_at;
    drive_frame(0, 16'd7, 16'd0, 1'b0);
    idle(1);
    wait_outputs(base + 10, 400, "reset_mid_burst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (do_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmb_abort: do_en=%b busy=%b required 0 0", do_en, busy);
    end
    cnt_at = q_pow.size();
    @(negedge clock);
    reset = 1'b1;
    idle(200);
    checks++;
    if (q_pow.size() != cnt_at) begin
      errors++;
      $display("FAIL rmb_no_resume: got %0d extra outputs required 0", q_pow.size() - cnt_at);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp(1'b0, "ramp");
    test_extremes();
    test_ramp(1'b1, "gapped");
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
